// File: rtl/sa_autosa_pdp_wdma_pack.sv
// sa_autosa_pdp_wdma_pack: write-side consumer of the PDP output stream.
// Accepts 8-byte pooled atoms, generates surface/line/width ordered byte
// addresses incrementally, buffers {addr, data, last} in a 2-entry skid FIFO
// and raises a one-cycle completion pulse per layer.
// Optional feature: define SA_AUTOSA_PDP_WDMA_PERF_EN to enable the
// back-pressure stall counter on dp2reg_wdma_stall (tied to 0 otherwise).
module sa_autosa_pdp_wdma_pack (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rstn,
  input  logic        reg2dp_op_en,
  input  logic [12:0] reg2dp_cube_out_width,
  input  logic [12:0] reg2dp_cube_out_height,
  input  logic [12:0] reg2dp_cube_out_channel,
  input  logic [31:0] reg2dp_dst_base_addr,
  input  logic [31:0] reg2dp_dst_line_stride,
  input  logic [31:0] reg2dp_dst_surface_stride,
  input  logic [63:0] pdp_dp2wdma_pd,
  input  logic        pdp_dp2wdma_valid,
  output logic        pdp_dp2wdma_ready,
  output logic        dma_wr_req_valid,
  input  logic        dma_wr_req_ready,
  output logic [31:0] dma_wr_req_addr,
  output logic [63:0] dma_wr_req_data,
  output logic        dma_wr_req_last,
  output logic        dp2reg_done,
  output logic        wdma_busy,
  output logic [31:0] dp2reg_wdma_stall
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 13;
  localparam int unsigned SW = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   w_max_q, w_max_d;
  logic [CW-1:0]   h_max_q, h_max_d;
  logic [SW-1:0]   s_max_q, s_max_d;
  logic [AW-1:0]   line_stride_q, line_stride_d;
  logic [AW-1:0]   surf_stride_q, surf_stride_d;
  logic [CW-1:0]   w_cnt_q, w_cnt_d;
  logic [CW-1:0]   h_cnt_q, h_cnt_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [AW-1:0]   line_addr_q, line_addr_d;
  logic [AW-1:0]   surf_addr_q, surf_addr_d;

  // skid FIFO: entry 0 is always the head
  logic            v0_q, v0_d, v1_q, v1_d;
  logic [AW-1:0]   a0_q, a0_d, a1_q, a1_d;
  logic [DW-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic            l0_q, l0_d, l1_q, l1_d;

  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            push_c, pop_c, is_last_c, start_c;
  logic [AW-1:0]   base_c;
  logic            unused_bits_c;

  assign base_c    = {reg2dp_dst_base_addr[AW-1:3], 3'b000};
  assign push_c    = pdp_dp2wdma_valid & ready_q;
  assign pop_c     = v0_q & dma_wr_req_ready;
  assign start_c   = (state_q == S_IDLE) & reg2dp_op_en;
  assign is_last_c = (w_cnt_q == w_max_q) & (h_cnt_q == h_max_q) & (s_cnt_q == s_max_q);

  assign unused_bits_c = ^{reg2dp_cube_out_channel[2:0], reg2dp_dst_base_addr[2:0],
                           reg2dp_dst_line_stride[2:0], reg2dp_dst_surface_stride[2:0]};

  // Next-state: skid FIFO, address walker and control FSM
  always_comb begin
    state_d       = state_q;
    w_max_d       = w_max_q;
    h_max_d       = h_max_q;
    s_max_d       = s_max_q;
    line_stride_d = line_stride_q;
    surf_stride_d = surf_stride_q;
    w_cnt_d       = w_cnt_q;
    h_cnt_d       = h_cnt_q;
    s_cnt_d       = s_cnt_q;
    cur_addr_d    = cur_addr_q;
    line_addr_d   = line_addr_q;
    surf_addr_d   = surf_addr_q;
    v0_d          = v0_q;
    v1_d          = v1_q;
    a0_d          = a0_q;
    a1_d          = a1_q;
    d0_d          = d0_q;
    d1_d          = d1_q;
    l0_d          = l0_q;
    l1_d          = l1_q;
    done_d        = 1'b0;

    // pop shifts the second entry to the head; push fills the first free slot
    if (pop_c) begin
      v0_d = v1_q;
      a0_d = a1_q;
      d0_d = d1_q;
      l0_d = l1_q;
      v1_d = 1'b0;
    end
    if (push_c) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        a0_d = cur_addr_q;
        d0_d = pdp_dp2wdma_pd;
        l0_d = is_last_c;
      end else begin
        v1_d = 1'b1;
        a1_d = cur_addr_q;
        d1_d = pdp_dp2wdma_pd;
        l1_d = is_last_c;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (reg2dp_op_en) begin
          w_max_d       = reg2dp_cube_out_width;
          h_max_d       = reg2dp_cube_out_height;
          s_max_d       = reg2dp_cube_out_channel[CW-1:3];
          line_stride_d = {reg2dp_dst_line_stride[AW-1:3], 3'b000};
          surf_stride_d = {reg2dp_dst_surface_stride[AW-1:3], 3'b000};
          w_cnt_d       = '0;
          h_cnt_d       = '0;
          s_cnt_d       = '0;
          cur_addr_d    = base_c;
          line_addr_d   = base_c;
          surf_addr_d   = base_c;
          state_d       = S_RUN;
        end
      end
      S_RUN: begin
        if (push_c) begin
          if (w_cnt_q != w_max_q) begin
            w_cnt_d    = w_cnt_q + CW'(1);
            cur_addr_d = cur_addr_q + AW'(8);
          end else if (h_cnt_q != h_max_q) begin
            w_cnt_d     = '0;
            h_cnt_d     = h_cnt_q + CW'(1);
            line_addr_d = line_addr_q + line_stride_q;
            cur_addr_d  = line_addr_q + line_stride_q;
          end else begin
            w_cnt_d     = '0;
            h_cnt_d     = '0;
            s_cnt_d     = s_cnt_q + SW'(1);
            surf_addr_d = surf_addr_q + surf_stride_q;
            line_addr_d = surf_addr_q + surf_stride_q;
            cur_addr_d  = surf_addr_q + surf_stride_q;
          end
          if (is_last_c) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!v0_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_RUN) & !v1_d;
    busy_d  = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q       <= S_IDLE;
      w_max_q       <= '0;
      h_max_q       <= '0;
      s_max_q       <= '0;
      line_stride_q <= '0;
      surf_stride_q <= '0;
      w_cnt_q       <= '0;
      h_cnt_q       <= '0;
      s_cnt_q       <= '0;
      cur_addr_q    <= '0;
      line_addr_q   <= '0;
      surf_addr_q   <= '0;
      v0_q          <= 1'b0;
      v1_q          <= 1'b0;
      a0_q          <= '0;
      a1_q          <= '0;
      d0_q          <= '0;
      d1_q          <= '0;
      l0_q          <= 1'b0;
      l1_q          <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      w_max_q       <= w_max_d;
      h_max_q       <= h_max_d;
      s_max_q       <= s_max_d;
      line_stride_q <= line_stride_d;
      surf_stride_q <= surf_stride_d;
      w_cnt_q       <= w_cnt_d;
      h_cnt_q       <= h_cnt_d;
      s_cnt_q       <= s_cnt_d;
      cur_addr_q    <= cur_addr_d;
      line_addr_q   <= line_addr_d;
      surf_addr_q   <= surf_addr_d;
      v0_q          <= v0_d;
      v1_q          <= v1_d;
      a0_q          <= a0_d;
      a1_q          <= a1_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      l0_q          <= l0_d;
      l1_q          <= l1_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef SA_AUTOSA_PDP_WDMA_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where the head request is held off
  always_comb begin
    stall_d = stall_q;
    if (start_c) begin
      stall_d = '0;
    end else if (v0_q & !dma_wr_req_ready & (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign dp2reg_wdma_stall = stall_q;
`else
  logic unused_start_c;
  assign unused_start_c    = start_c;
  assign dp2reg_wdma_stall = '0;
`endif

  assign pdp_dp2wdma_ready = ready_q;
  assign dma_wr_req_valid  = v0_q;
  assign dma_wr_req_addr   = a0_q;
  assign dma_wr_req_data   = d0_q;
  assign dma_wr_req_last   = l0_q;
  assign dp2reg_done       = done_q;
  assign wdma_busy         = busy_q;

endmodule

// File: doc/sa_autosa_pdp_wdma_pack.md
# sa_autosa_pdp_wdma_pack

Write-side consumer of the PDP core output stream. It accepts 8-byte pooled atoms on the `pdp_dp2wdma` valid/ready interface and generates addresses in surface-major, line-major, width-minor order. It emits one DMA write request per atom, and signals per-layer completion to the register file. It sits between the PDP core and the memory-interface write arbiter.

## Interface
Parameters:
- None. Widths are fixed: atom 64 bits (8 channels x int8), address 32 bits.

Ports:
- `autosa_core_clk` in 1: clock.
- `autosa_core_rstn` in 1: reset, asynchronous, active-low.
- `reg2dp_op_en` in 1: single-cycle start pulse. Sampled only in IDLE.
- `reg2dp_cube_out_width` in 13: output width minus 1.
- `reg2dp_cube_out_height` in 13: output height minus 1.
- `reg2dp_cube_out_channel` in 13: channels minus 1. Surfaces = `channel[12:3]` + 1.
- `reg2dp_dst_base_addr` in 32: cube base byte address. Bits [2:0] are ignored (treated as 0).
- `reg2dp_dst_line_stride` in 32: byte stride between lines. Bits [2:0] are ignored.
- `reg2dp_dst_surface_stride` in 32: byte stride between surfaces. Bits [2:0] are ignored.
- `pdp_dp2wdma_pd` in 64: pooled atom.
- `pdp_dp2wdma_valid` in 1: atom valid.
- `pdp_dp2wdma_ready` out 1: atom accepted when valid & ready.
- `dma_wr_req_valid` out 1: write request valid.
- `dma_wr_req_ready` in 1: arbiter accepts the request.
- `dma_wr_req_addr` out 32: byte address of the atom.
- `dma_wr_req_data` out 64: atom data, unchanged.
- `dma_wr_req_last` out 1: set on the final atom of the cube.
- `dp2reg_done` out 1: one-cycle completion pulse.
- `wdma_busy` out 1: high in every state except IDLE.
- `dp2reg_wdma_stall` out 32: back-pressure cycle count (see Configuration).

Reset values: every output is 0, including `dp2reg_wdma_stall`. Internal state resets to IDLE.

## Operation
State machine:
- **IDLE**: on `reg2dp_op_en`, latch all `reg2dp_*` fields, set `line_addr = surf_addr = cur_addr = base`, clear the w/h/s counters, then go to RUN.
- **RUN**: accept atoms. After the atom with w=W, h=H, s=S is accepted, go to DRAIN.
- **DRAIN**: wait for the skid buffer to empty, i.e. the request carrying `last` has been accepted. Then go to DONE.
- **DONE**: assert `dp2reg_done` for one cycle, then go to IDLE.

Ready rule:
- `pdp_dp2wdma_ready = (state==RUN) & !skid_full`.
- Ready is 0 in IDLE, DRAIN and DONE.
- `reg2dp_op_en` outside IDLE is ignored.

Address generation is incremental; there are no multipliers. On each accepted atom:
- If w < W: w++ and `cur_addr += 8`.
- Else if h < H: w=0, h++, `line_addr += line_stride`, `cur_addr = line_addr + line_stride`.
- Else: w=0, h=0, s++, `surf_addr += surface_stride`, and `line_addr = cur_addr = surf_addr + surface_stride`.

Address arithmetic:
- All address arithmetic is modulo 2^32. Wrap-around is silent.
- The request address is the `cur_addr` value *before* the update.

Output buffer:
- The output buffer is a 2-entry skid FIFO of {addr, data, last}.
- `dma_wr_req_*` is driven from the FIFO head.
- `dma_wr_req_addr`, `dma_wr_req_data` and `dma_wr_req_last` are held stable while `dma_wr_req_valid & !dma_wr_req_ready`.

Simultaneous push and pop:
- A push and a pop in the same cycle are both honoured.
- When the FIFO is full, a pop in the same cycle frees space the next cycle. Ready is registered and does not combinationally follow `dma_wr_req_ready`.

Degenerate and abort cases:
- Total atoms = (W+1)(H+1)(S+1). With W=H=S=0, a single atom is sent with `last`=1.
- Reset mid-operation drops any buffered requests without emitting them; `dp2reg_done` is not pulsed.

## Timing
- Latency from atom accept (cycle N) to `dma_wr_req_valid` is N+1 with no back-pressure.
- Sustained throughput is 1 atom/cycle.
- `dp2reg_done` asserts in the cycle after the state machine enters DONE. This is 2 cycles after the `last` request is accepted.
- `wdma_busy` rises the cycle after `reg2dp_op_en` and falls with the DONE→IDLE transition.
- A new `reg2dp_op_en` can be accepted in the cycle after `dp2reg_done`.

## Configuration
Macro `SA_AUTOSA_PDP_WDMA_PERF_EN`:
- **Defined**: `dp2reg_wdma_stall` is a 32-bit counter.
  - Cleared on start.
  - Increments each cycle with `dma_wr_req_valid & !dma_wr_req_ready`.
  - Saturates at 0xFFFFFFFF.
  - Holds its value after DONE.
- **Undefined**: `dp2reg_wdma_stall` is tied to 0 and no counter flops are present. The port remains.

## Test plan
1. **Single atom**: W=H=0, C=7, base=0x1000, `dma_wr_req_ready`=1. Expect one request with addr 0x1000, `last`=1, and `dp2reg_done` 2 cycles later.
2. **Full order**: W=3, H=1, C=15, base=0x0, line=0x100, surface=0x1000. Expect 16 requests with addresses 0x0,0x8,0x10,0x18, 0x100..0x118, 0x1000..0x1018, 0x1100..0x1118, and `last` on the 16th only.
3. **Back-pressure**: as test 2, with `dma_wr_req_ready` toggling 1 cycle on / 3 cycles off. Expect no loss or duplication, data unchanged in order, and `dp2reg_wdma_stall` equal to the count of stalled cycles (with PERF_EN).
4. **Wrap**: base=0xFFFFFFF8, W=1. Expect addresses 0xFFFFFFF8 then 0x00000000.
5. **Ignored start**: `reg2dp_op_en` pulsed during RUN. Expect the configuration unchanged and exactly one `dp2reg_done`.
6. **Reset abort**: assert `autosa_core_rstn`=0 after 5 of 16 atoms. Expect all outputs 0 and IDLE. A subsequent run of test 2 must pass.
